// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard sequencer: PC select encodings,
// FSM state type and the bubble word loaded by a flush.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] PCSEL_SEQ   = 2'b00;
    localparam logic [1:0] PCSEL_REDIR = 2'b01;
    localparam logic [1:0] PCSEL_EXC   = 2'b10;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Load-stall down-counter width; covers LOAD_STALL_CYCLES up to 7.
    localparam int unsigned LCNT_W = 3;

    typedef enum logic [1:0] {
        StRun,
        StLoadStall,
        StMemWait
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EX. Register 0 never creates a dependency.
module pipe_hazard_ctrl_hazard_detect (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_uses_rs && (id_rs == ex_rt);
    assign rt_hit   = id_uses_rt && (id_rt == ex_rt);
    assign load_use = ex_memread && (ex_rt != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Control outputs are
// combinational; FSM, load-stall counter, pending redirect and stall counter are registered.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             redirect,
    input  logic             dmem_busy,
    input  logic             imem_ready,
    input  logic             exc_req,
    output logic             wr_pc,
    output logic             wr_IF2ID,
    output logic             wr_ID2EX,
    output logic             wr_EX2MEM,
    output logic             flush_IF2ID,
    output logic             flush_ID2EX,
    output logic             flush_EX2MEM,
    output logic [1:0]       pc_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [LCNT_W-1:0] LoadCntInit = LCNT_W'(LOAD_STALL_CYCLES - 1);

    hz_state_e         state_q, state_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic load_use;
    logic redir_any;
    logic in_stall;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .load_use   (load_use)
    );

    assign redir_any = redirect | pend_q;
    // MEM_WAIT behaves as RUN once the memory stops being busy.
    assign in_stall  = (state_q == StLoadStall);
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            lcnt_q      <= '0;
            pend_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            pend_q  <= pend_d;
            if (!wr_pc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        pend_d  = pend_q;
        if (exc_req) begin
            state_d = StRun;
            lcnt_d  = '0;
            pend_d  = 1'b0;
        end else if (dmem_busy) begin
            state_d = StMemWait;
            if (redirect) begin
                pend_d = 1'b1;
            end
        end else if (in_stall) begin
            lcnt_d  = lcnt_q - LCNT_W'(1);
            state_d = (lcnt_q <= LCNT_W'(1)) ? StRun : StLoadStall;
        end else if (redir_any) begin
            state_d = StRun;
            pend_d  = 1'b0;
        end else if (load_use) begin
            lcnt_d  = LoadCntInit;
            state_d = (LoadCntInit != '0) ? StLoadStall : StRun;
        end else begin
            state_d = StRun;
        end
    end

    always_comb begin
        wr_pc        = 1'b1;
        wr_IF2ID     = 1'b1;
        wr_ID2EX     = 1'b1;
        wr_EX2MEM    = 1'b1;
        flush_IF2ID  = 1'b0;
        flush_ID2EX  = 1'b0;
        flush_EX2MEM = 1'b0;
        pc_sel       = PCSEL_SEQ;
        if (reset) begin
            wr_pc        = 1'b0;
            wr_IF2ID     = 1'b0;
            wr_ID2EX     = 1'b0;
            wr_EX2MEM    = 1'b0;
            flush_IF2ID  = 1'b1;
            flush_ID2EX  = 1'b1;
            flush_EX2MEM = 1'b1;
        end else if (exc_req) begin
            flush_IF2ID  = 1'b1;
            flush_ID2EX  = 1'b1;
            flush_EX2MEM = 1'b1;
            pc_sel       = PCSEL_EXC;
        end else if (dmem_busy) begin
            wr_pc     = 1'b0;
            wr_IF2ID  = 1'b0;
            wr_ID2EX  = 1'b0;
            wr_EX2MEM = 1'b0;
        end else if (in_stall) begin
            // ID is held during a load stall, so no redirect can originate here.
            wr_pc       = 1'b0;
            wr_IF2ID    = 1'b0;
            flush_ID2EX = 1'b1;
        end else if (redir_any) begin
            flush_IF2ID = 1'b1;
            pc_sel      = PCSEL_REDIR;
        end else if (load_use) begin
            wr_pc       = 1'b0;
            wr_IF2ID    = 1'b0;
            flush_ID2EX = 1'b1;
        end else if (!imem_ready) begin
            wr_pc       = 1'b0;
            wr_IF2ID    = 1'b0;
            flush_IF2ID = 1'b1;
        end
    end

endmodule
